// File: rtl/fir_pkg.sv
// Shared FIR-path definitions: sample format and default buffering parameters.
package fir_pkg;

    localparam int SAMPLE_W       = 11;
    localparam int FIR_BUF_DEPTH  = 8;
    localparam int FIR_DROP_CNT_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/fir_buf_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module fir_buf_mem #(
    parameter  int DEPTH = 8,
    parameter  int W     = 11,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // No reset on the array: contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_buffer.sv
// Elastic FWFT output stage for the FIR: never stalls the filter, counts
// samples lost on overflow, re-issues data through a valid/ready handshake.
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter  int W     = SAMPLE_W,
    parameter  int DEPTH = FIR_BUF_DEPTH,
    parameter  int CNT_W = FIR_DROP_CNT_W,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W-1:0]     DIN,
    input  logic             VIN,
    output logic [W-1:0]     DOUT,
    output logic             VOUT,
    input  logic             RDY,
    output logic [LW-1:0]    LEVEL,
    output logic             FULL,
    output logic             OVF,
    output logic [CNT_W-1:0] DROP_CNT
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic          push;
    logic          pop;
    logic          drop;
    logic [W-1:0]  mem_rdata;
    logic [W-1:0]  head_next;

    assign pop     = VOUT && RDY;
    assign push    = VIN && (!FULL || pop);
    assign drop    = VIN && FULL && !pop;
    assign rd_next = pop ? rd_ptr + PW'(1) : rd_ptr;

    assign LEVEL = level;
    assign FULL  = (level == LW'(DEPTH));

    fir_buf_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (CLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (DIN),
        .raddr (rd_next),
        .rdata (mem_rdata)
    );

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // The incoming sample becomes the new head when it lands on the slot
    // the read pointer is about to point at (empty, or level 1 with pop).
    always_comb begin
        head_next = mem_rdata;
        if (push && (wr_ptr == rd_next)) begin
            head_next = DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            VOUT     <= 1'b0;
            DOUT     <= '0;
            OVF      <= 1'b0;
            DROP_CNT <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            level  <= level_next;
            VOUT   <= (level_next != '0);
            DOUT   <= (level_next != '0) ? head_next : '0;
            if (drop) begin
                OVF <= 1'b1;
                if (DROP_CNT != '1) begin
                    DROP_CNT <= DROP_CNT + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Bench for fir_out_buffer: directed plan steps plus random traffic, checked
// against a queue-based model of the buffer.
module tb_fir_out_buffer;

    localparam int W      = fir_pkg::SAMPLE_W;
    localparam int DEPTH  = 8;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int CNT_W  = 8;
    localparam int CNT2_W = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic [W-1:0]      DIN;
    logic              VIN;
    logic              RDY;
    logic [W-1:0]      DOUT, DOUT2;
    logic              VOUT, VOUT2;
    logic [LW-1:0]     LEVEL, LEVEL2;
    logic              FULL, FULL2;
    logic              OVF, OVF2;
    logic [CNT_W-1:0]  DROP_CNT;
    logic [CNT2_W-1:0] DROP_CNT2;

    always #5 CLK = ~CLK;

    fir_out_buffer #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .DOUT(DOUT), .VOUT(VOUT),
        .RDY(RDY), .LEVEL(LEVEL), .FULL(FULL), .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    fir_out_buffer #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT2_W)) dut_sat (
        .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .DOUT(DOUT2), .VOUT(VOUT2),
        .RDY(RDY), .LEVEL(LEVEL2), .FULL(FULL2), .OVF(OVF2), .DROP_CNT(DROP_CNT2)
    );

    // Reference model: plain FIFO queue plus overflow bookkeeping.
    logic [W-1:0] q[$];
    bit           m_ovf;
    int           m_drops;
    int           n_vec;
    int           n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit after_rst);
        int sz;
        int d_exp;
        int d2_exp;
        sz     = q.size();
        d_exp  = (m_drops > 255) ? 255 : m_drops;
        d2_exp = (m_drops > 3) ? 3 : m_drops;
        chk({tag, ".vout"},  32'(VOUT),      32'(sz != 0));
        chk({tag, ".level"}, 32'(LEVEL),     32'(sz));
        chk({tag, ".full"},  32'(FULL),      32'(sz == DEPTH));
        chk({tag, ".ovf"},   32'(OVF),       32'(m_ovf));
        chk({tag, ".drop"},  32'(DROP_CNT),  32'(d_exp));
        chk({tag, ".drop2"}, 32'(DROP_CNT2), 32'(d2_exp));
        chk({tag, ".level2"}, 32'(LEVEL2),   32'(sz));
        if (sz != 0) begin
            chk({tag, ".dout"},  32'(DOUT),  32'(q[0]));
            chk({tag, ".dout2"}, 32'(DOUT2), 32'(q[0]));
        end else if (after_rst) begin
            chk({tag, ".dout_rst"}, 32'(DOUT), 32'(0));
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input string tag, input bit rst, input bit vin,
                        input logic [W-1:0] din, input bit rdy);
        bit was_full;
        bit popped;
        RST = rst;
        VIN = vin;
        DIN = din;
        RDY = rdy;
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            popped   = (q.size() != 0) && rdy;
            if (popped) void'(q.pop_front());
            if (vin) begin
                if (!was_full || popped) begin
                    q.push_back(din);
                end else begin
                    m_ovf = 1'b1;
                    m_drops++;
                end
            end
        end
        @(posedge CLK);
        #1;
        check_all(tag, rst);
    endtask

    initial begin
        logic [W-1:0] fill_vals[8];
        n_vec   = 0;
        n_err   = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        RST = 1'b1; VIN = 1'b0; DIN = '0; RDY = 1'b0;
        fill_vals = '{11'(-1024), 11'(-1), 11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd1023};
        @(posedge CLK);
        #1;

        // Reset then idle
        for (int i = 0; i < 3; i++) step("reset", 1, 0, '0, 0);
        for (int i = 0; i < 10; i++) step("idle", 0, 0, '0, 1);

        // Streaming pass-through
        for (int i = 0; i < 20; i++) begin
            step("stream", 0, 1, W'(i), 1);
            chk("stream.level_le1", 32'(LEVEL <= 1), 32'(1));
        end
        for (int i = 0; i < 2; i++) step("stream_drain", 0, 0, '0, 1);

        // Fill and stall with boundary values, then drain
        for (int i = 0; i < 8; i++) step("fill", 0, 1, fill_vals[i], 0);
        chk("fill.full", 32'(FULL), 32'(1));
        for (int i = 0; i < 9; i++) step("fill_drain", 0, 0, '0, 1);

        // Overflow: 3 drops, then 2 more to saturate the 2-bit counter
        for (int i = 0; i < 8; i++) step("ovf_fill", 0, 1, W'($urandom), 0);
        for (int i = 0; i < 3; i++) step("ovf3", 0, 1, W'($urandom), 0);
        chk("ovf3.cnt", 32'(DROP_CNT), 32'(3));
        for (int i = 0; i < 2; i++) step("ovf5", 0, 1, W'($urandom), 0);
        chk("ovf5.sat", 32'(DROP_CNT2), 32'(3));
        for (int i = 0; i < 9; i++) step("ovf_drain", 0, 0, '0, 1);

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 8; i++) step("pp_fill", 0, 1, W'(10 + i), 0);
        step("pp_both", 0, 1, W'(99), 1);
        for (int i = 0; i < 9; i++) step("pp_drain", 0, 0, '0, 1);

        // Reset mid-operation with OVF set and five samples queued
        for (int i = 0; i < 5; i++) step("mid_fill", 0, 1, W'(200 + i), 0);
        step("mid_rst", 1, 1, W'(7), 1);
        step("mid_push", 0, 1, W'(42), 0);
        chk("mid_push.dout", 32'(DOUT), 32'(42));
        step("mid_drain", 0, 0, '0, 1);

        // Random traffic with varying consumer pressure
        for (int i = 0; i < 400; i++) begin
            int rdy_pct;
            rdy_pct = (i < 200) ? 30 : 80;
            step("rand", ($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 70),
                 W'($urandom), ($urandom_range(0, 99) < rdy_pct));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_out_buffer.md
Name: fir_out_buffer

Overview:
- Elastic output stage directly downstream of the 10-tap FIR filter.
- Captures every FIR result presented on DIN/VIN. The FIR has no backpressure input, so this block cannot stall it.
- Re-issues results to a consumer (data sink, DMA, serializer) through a valid/ready handshake.
- Detects and counts samples dropped on overflow, so the bench and the system can see lost FIR outputs.

Parameters:
- W, 11, sample width; matches FIR DOUT width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- CLK  in  1  single system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- DIN  in  W  FIR output sample, two's complement.
- VIN  in  1  DIN valid; driven by the FIR's VOUT; may be high every cycle.
- DOUT  out  W  head-of-queue sample.
- VOUT  out  1  DOUT valid.
- RDY  in  1  consumer ready; a pop occurs when VOUT && RDY.
- LEVEL  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- FULL  out  1  LEVEL == DEPTH.
- OVF  out  1  sticky: at least one sample dropped since reset.
- DROP_CNT  out  CNT_W  number of dropped samples; saturates at all-ones.

Behaviour:
- Reset is synchronous and active-high, sampled on the CLK rising edge. While RST=1, on each edge:
  - read/write pointers, LEVEL, OVF and DROP_CNT clear to 0;
  - VOUT=0, FULL=0, DOUT=0.
  - Array contents are don't-care.
  - RST overrides VIN/RDY in the same cycle. Asserting RST mid-stream discards all queued samples, and no pop is reported.
- Storage is first-word-fall-through. DOUT/VOUT are registered from queue state: VOUT = (LEVEL != 0) and DOUT = mem[rd_ptr], both valid the cycle after the state update.
- Latency: a sample written at edge N into an empty buffer shows VOUT=1 and DOUT=sample after edge N. Empty-in to valid-out takes 1 clock.
- pop = VOUT && RDY. On pop, rd_ptr advances at the edge.
- push = VIN && (!FULL || pop). Pushing into a full buffer is allowed when a pop happens in the same cycle.
- LEVEL update at each edge:
  - +1 when push && !pop;
  - −1 when pop && !push;
  - unchanged when both or neither occur.
- Drop condition: VIN && FULL && !pop.
  - The sample is discarded and no pointer moves.
  - OVF is set to 1 and stays at 1 until RST.
  - DROP_CNT increments unless it is already 2^CNT_W−1, in which case it holds.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. LEVEL is tracked explicitly, so full and empty are unambiguous.
- RDY while empty has no effect. VIN=0 never changes state.
- Order is strictly FIFO. Sample values are passed bit-exact, with no rounding or saturation.
- No combinational path from RDY or VIN to any output.
- Simultaneous push and pop at LEVEL=1: after the edge, DOUT shows the newly pushed sample and VOUT stays high.

Decomposition:
- Shared package fir_pkg:
  - SAMPLE_W = 11;
  - typedef logic signed [SAMPLE_W-1:0] sample_t;
  - default DEPTH and CNT_W constants.
- The FIR, data maker and this block all import fir_pkg.
- One sub-module: fir_buf_mem, a DEPTH×W register array with one synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr → rdata).
- Pointer, level, handshake and overflow logic stay in fir_out_buffer.

Test Plan:
- Reset then idle: RST=1 for 3 cycles, then VIN=0 and RDY=1 for 10 cycles → VOUT=0, LEVEL=0, OVF=0, DROP_CNT=0 throughout.
- Streaming pass-through: RDY=1, VIN=1 for 20 cycles with DIN=0,1,…,19 → DOUT sequence 0..19 with VOUT=1, starting 1 cycle after the first push; LEVEL never exceeds 1.
- Fill and stall: RDY=0, push 8 samples −1024, −1, 0, 1, 2, 3, 4, 1023 → FULL=1, LEVEL=8, OVF=0. Then RDY=1 → the same eight values leave in order and LEVEL returns to 0.
- Overflow: with the buffer full and RDY=0, present 3 more samples → DROP_CNT=3, OVF=1, LEVEL=8, queued contents unchanged. With CNT_W=2, 5 drops → DROP_CNT=3 (saturated).
- Full with simultaneous push/pop: buffer full holding 10..17, RDY=1, VIN=1, DIN=99 for one cycle → 10 popped, 99 accepted, LEVEL stays 8, no drop. Drain yields 11..17 then 99.
- Reset mid-operation: LEVEL=5 and OVF=1, assert RST for 1 cycle → VOUT=0, LEVEL=0, OVF=0, DROP_CNT=0. The next push of 42 appears on DOUT one cycle later.
